// File: rtl/seg7_scan_display.sv
// Scanned 8-digit seven-segment driver for the $v0/$v1 debug outputs.
// Periodically snapshots v0[15:0] and v1[15:0], then time-multiplexes them
// as hex digits: v1 on digits 7..4, v0 on digits 3..0. All outputs are registered.
module seg7_scan_display #(
    parameter int REFRESH_DIV = 100000,   // clk cycles per digit slot
    parameter int GUARD       = 16,       // anode-off cycles at the start of each slot
    parameter int UPDATE_DIV  = 50000000  // clk cycles between snapshot captures
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic [31:0] v0,
    input  logic [31:0] v1,
    input  logic        Freeze,
    input  logic        BlankLZ,
    output logic [6:0]  Seg,
    output logic        DP,
    output logic [7:0]  An,
    output logic [2:0]  Scan
);

    localparam int RW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int UW = (UPDATE_DIV > 1) ? $clog2(UPDATE_DIV) : 1;

    localparam logic [RW-1:0] REF_LAST  = RW'(REFRESH_DIV - 1);
    localparam logic [RW-1:0] REF_GUARD = RW'(GUARD);
    localparam logic [UW-1:0] UPD_LAST  = UW'(UPDATE_DIV - 1);

    logic [UW-1:0] upd_cnt_reg;
    logic [15:0]   snap0_reg;
    logic [15:0]   snap1_reg;
    logic [RW-1:0] ref_cnt_reg;
    logic [2:0]    idx_reg;
    logic [7:0]    an_reg;
    logic [6:0]    seg_reg;

    logic [15:0]   group_val;
    logic [3:0]    nibble;
    logic [3:0]    nib_zero;
    logic [3:0]    hi_zero;
    logic          blank;
    logic [7:0]    an_next;
    logic [6:0]    seg_next;

    // Upper halves of v0/v1 are intentionally not displayed.
    logic unused_hi;
    assign unused_hi = ^{v0[31:16], v1[31:16]};

    // Hex to active-low {g,f,e,d,c,b,a}.
    function automatic logic [6:0] decode(input logic [3:0] n);
        case (n)
            4'h0: decode = 7'h40;
            4'h1: decode = 7'h79;
            4'h2: decode = 7'h24;
            4'h3: decode = 7'h30;
            4'h4: decode = 7'h19;
            4'h5: decode = 7'h12;
            4'h6: decode = 7'h02;
            4'h7: decode = 7'h78;
            4'h8: decode = 7'h00;
            4'h9: decode = 7'h10;
            4'hA: decode = 7'h08;
            4'hB: decode = 7'h03;
            4'hC: decode = 7'h46;
            4'hD: decode = 7'h21;
            4'hE: decode = 7'h06;
            default: decode = 7'h0E;
        endcase
    endfunction

    // Snapshot timer; reset value makes the first edge after release capture.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            upd_cnt_reg <= UPD_LAST;
            snap0_reg   <= '0;
            snap1_reg   <= '0;
        end else if (upd_cnt_reg == UPD_LAST) begin
            upd_cnt_reg <= '0;
            if (!Freeze) begin
                snap0_reg <= v0[15:0];
                snap1_reg <= v1[15:0];
            end
        end else begin
            upd_cnt_reg <= upd_cnt_reg + 1'b1;
        end
    end

    // Slot timer and digit index; idx wraps 7 -> 0 naturally in 3 bits.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            ref_cnt_reg <= '0;
            idx_reg     <= '0;
        end else if (ref_cnt_reg == REF_LAST) begin
            ref_cnt_reg <= '0;
            idx_reg     <= idx_reg + 3'd1;
        end else begin
            ref_cnt_reg <= ref_cnt_reg + 1'b1;
        end
    end

    assign group_val = idx_reg[2] ? snap1_reg : snap0_reg;
    assign nibble    = group_val[{idx_reg[1:0], 2'b00} +: 4];

    // hi_zero[k]: nibble k and every higher nibble of the group are zero.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_zero
            assign nib_zero[gi] = (group_val[4*gi +: 4] == 4'h0);
            if (gi == 3) begin : g_top
                assign hi_zero[gi] = nib_zero[gi];
            end else begin : g_lower
                assign hi_zero[gi] = nib_zero[gi] & hi_zero[gi+1];
            end
        end
    endgenerate

    // Digit 0 of each group is never blanked so a zero value still shows "0".
    assign blank = BlankLZ && (idx_reg[1:0] != 2'd0) && hi_zero[idx_reg[1:0]];

    // Next anode/segment pattern; anodes stay dark during the guard window.
    always_comb begin
        an_next = 8'hFF;
        if (ref_cnt_reg >= REF_GUARD) begin
            an_next[idx_reg] = 1'b0;
        end
        seg_next = blank ? 7'h7F : decode(nibble);
    end

    // Output registers.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            an_reg  <= 8'hFF;
            seg_reg <= 7'h7F;
        end else begin
            an_reg  <= an_next;
            seg_reg <= seg_next;
        end
    end

    assign An   = an_reg;
    assign Seg  = seg_reg;
    assign DP   = 1'b1;
    assign Scan = idx_reg;

endmodule

// File: tb/tb_seg7_scan_display.sv
// Directed testbench for seg7_scan_display (REFRESH_DIV=4, GUARD=1, UPDATE_DIV=8).
module tb_seg7_scan_display;

    logic        clk;
    logic        clk_en;
    logic        Reset;
    logic [31:0] v0;
    logic [31:0] v1;
    logic        Freeze;
    logic        BlankLZ;
    logic [6:0]  Seg;
    logic        DP;
    logic [7:0]  An;
    logic [2:0]  Scan;

    int checks;
    int errors;
    int edge_n;

    // Expected segment codes for digits 0..3 of 0x1234.
    localparam logic [6:0] SEG_1234 [4] = '{7'h19, 7'h30, 7'h24, 7'h79};

    seg7_scan_display #(
        .REFRESH_DIV(4),
        .GUARD(1),
        .UPDATE_DIV(8)
    ) dut (
        .Clk(clk),
        .Reset(Reset),
        .v0(v0),
        .v1(v1),
        .Freeze(Freeze),
        .BlankLZ(BlankLZ),
        .Seg(Seg),
        .DP(DP),
        .An(An),
        .Scan(Scan)
    );

    // Gated clock so reset can be exercised with no edges.
    always begin
        #5;
        if (clk_en) clk = ~clk;
    end

    // Rising edges since reset release.
    always @(posedge clk or posedge Reset) begin
        if (Reset) edge_n <= 0;
        else       edge_n <= edge_n + 1;
    end

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    // Wait (bounded) until digit d is the lit one.
    task automatic wait_slot(input int d, output bit found);
        logic [7:0] want;
        want = 8'hFF;
        want[d] = 1'b0;
        found = 0;
        for (int c = 0; c < 48 && !found; c++) begin
            @(negedge clk);
            if (An === want) found = 1;
        end
    endtask

    task automatic test_reset;
        // get mid-scan first
        cycles(13);
        clk_en = 0;
        #3;
        Reset = 1;
        #1;
        checks++; if (An !== 8'hFF) begin errors++; $display("FAIL reset_an got %h want ff", An); end
        checks++; if (Seg !== 7'h7F) begin errors++; $display("FAIL reset_seg got %h want 7f", Seg); end
        checks++; if (DP !== 1'b1) begin errors++; $display("FAIL reset_dp got %b want 1", DP); end
        checks++; if (Scan !== 3'd0) begin errors++; $display("FAIL reset_scan got %0d want 0", Scan); end
        $display("reset: An=%h Seg=%h DP=%b Scan=%0d", An, Seg, DP, Scan);
        #40;
        clk_en = 1;
        cycles(5);
        checks++; if (An !== 8'hFF || Seg !== 7'h7F || Scan !== 3'd0) begin
            errors++; $display("FAIL reset_hold got An=%h Seg=%h Scan=%0d want ff 7f 0", An, Seg, Scan);
        end
    endtask

    task automatic test_basic;
        bit found;
        v0 = 32'h0000_1234;
        v1 = 32'h0000_ABCD;
        BlankLZ = 0;
        Freeze = 0;
        Reset = 0;
        @(negedge clk);
        checks++; if (An !== 8'hFF || Scan !== 3'd0 || Seg !== 7'h40) begin
            errors++; $display("FAIL first_edge got An=%h Seg=%h Scan=%0d want ff 40 0", An, Seg, Scan);
        end
        @(negedge clk);
        checks++; if (An !== 8'hFE) begin errors++; $display("FAIL slot0_an got %h want fe", An); end
        checks++; if (Seg !== 7'h19) begin errors++; $display("FAIL slot0_seg got %h want 19", Seg); end
        $display("slot0: An=%h Seg=%h", An, Seg);
        wait_slot(4, found);
        checks++; if (!found) begin errors++; $display("FAIL slot4_timeout An=%h want ef", An); end
        else if (Seg !== 7'h21) begin errors++; $display("FAIL slot4_seg got %h want 21", Seg); end
        $display("slot4: An=%h Seg=%h", An, Seg);
        wait_slot(7, found);
        checks++; if (!found) begin errors++; $display("FAIL slot7_timeout An=%h want 7f", An); end
        else if (Seg !== 7'h08) begin errors++; $display("FAIL slot7_seg got %h want 08", Seg); end
        $display("slot7: An=%h Seg=%h", An, Seg);
    endtask

    task automatic test_scan;
        int n;
        logic [7:0] want_an;
        logic [2:0] want_scan;
        for (int i = 0; i < 32; i++) begin
            @(negedge clk);
            n = edge_n;
            want_scan = 3'((n / 4) % 8);
            want_an = 8'hFF;
            if (((n - 1) % 4) != 0) want_an[((n - 1) / 4) % 8] = 1'b0;
            checks++;
            if (Scan !== want_scan || An !== want_an) begin
                errors++;
                $display("FAIL scan_cycle%0d got Scan=%0d An=%h want Scan=%0d An=%h", n, Scan, An, want_scan, want_an);
            end
        end
        $display("scan: 32 cycles, last Scan=%0d An=%h", Scan, An);
    endtask

    task automatic test_freeze;
        bit found;
        Freeze = 1;
        v0 = 32'h0000_FFFF;
        cycles(24);
        for (int d = 0; d < 4; d++) begin
            wait_slot(d, found);
            checks++;
            if (!found) begin errors++; $display("FAIL frozen_d%0d_timeout An=%h", d, An); end
            else if (Seg !== SEG_1234[d]) begin
                errors++; $display("FAIL frozen_d%0d got %h want %h", d, Seg, SEG_1234[d]);
            end
        end
        $display("freeze: right digits held");
        Freeze = 0;
        cycles(9);
        for (int d = 0; d < 4; d++) begin
            wait_slot(d, found);
            checks++;
            if (!found) begin errors++; $display("FAIL unfrozen_d%0d_timeout An=%h", d, An); end
            else if (Seg !== 7'h0E) begin
                errors++; $display("FAIL unfrozen_d%0d got %h want 0e", d, Seg);
            end
        end
        $display("unfreeze: right digits F");
    endtask

    task automatic test_blank_lz;
        bit found;
        logic [6:0] want;
        BlankLZ = 1;
        v0 = 32'h0000_0050;
        v1 = 32'h0000_0000;
        cycles(10);
        for (int d = 0; d < 8; d++) begin
            case (d)
                0, 4:    want = 7'h40;
                1:       want = 7'h12;
                default: want = 7'h7F;
            endcase
            wait_slot(d, found);
            checks++;
            if (!found) begin errors++; $display("FAIL blank_d%0d_timeout An=%h", d, An); end
            else if (Seg !== want) begin
                errors++; $display("FAIL blank_d%0d got %h want %h", d, Seg, want);
            end
        end
        $display("blank_lz: v0=0050 v1=0000 checked");
    endtask

    task automatic test_upper_ignored;
        bit found;
        BlankLZ = 0;
        v0 = 32'hFFFF_0000;
        cycles(10);
        for (int d = 0; d < 4; d++) begin
            wait_slot(d, found);
            checks++;
            if (!found) begin errors++; $display("FAIL upper_d%0d_timeout An=%h", d, An); end
            else if (Seg !== 7'h40) begin
                errors++; $display("FAIL upper_d%0d got %h want 40", d, Seg);
            end
        end
        checks++; if (DP !== 1'b1) begin errors++; $display("FAIL dp_run got %b want 1", DP); end
        $display("upper: v0=ffff0000 shows 0000");
    endtask

    initial begin
        checks = 0;
        errors = 0;
        clk = 0;
        clk_en = 1;
        Reset = 1;
        Freeze = 0;
        BlankLZ = 0;
        v0 = 32'h0000_1234;
        v1 = 32'h0000_ABCD;
        cycles(2);
        Reset = 0;
        test_reset;
        test_basic;
        test_scan;
        test_freeze;
        test_blank_lz;
        test_upper_ignored;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
